// File: rtl/transmitter.sv
// UART serializer: byte in over valid/ready, framed as start, 8 data bits LSB first,
// optional parity and 1-2 stop bits. A 1-deep holding register allows gap-free frames.
module transmitter #(
  parameter int CLKS_PER_BIT = 868,  // 100 MHz clock, 115200 baud
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enabled,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  output logic       out,
  output logic       busy,
  output logic       done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic                stop_cnt_q, stop_cnt_d;
  logic [7:0]          shreg_q, shreg_d;
  logic [7:0]          hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic                out_q, out_d;
  logic                done_q, done_d;
  logic                bit_end;
  logic                load;

  assign ready   = !hold_full_q && enabled && !rst;
  assign busy    = (state_q != IDLE);
  assign out     = out_q;
  assign done    = done_q;
  assign bit_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_idx_d   = bit_idx_q;
    stop_cnt_d  = stop_cnt_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    out_d       = out_q;
    done_d      = 1'b0;
    load        = 1'b0;

    if (valid && ready) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
    end

    // shreg is never shifted, so it still holds the whole byte for the parity bit
    case (state_q)
      IDLE: begin
        if (hold_full_q && enabled) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          out_d   = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              out_d   = (^shreg_q) ^ (PARITY_ODD != 0);
            end else begin
              state_d    = STOP;
              out_d      = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            out_d     = shreg_q[bit_idx_q + 3'd1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          out_d      = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            done_d = 1'b1;
            if (hold_full_q && enabled) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              out_d   = 1'b1;
            end
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d     = START;
      shreg_d     = hold_q;
      hold_full_d = 1'b0;
      out_d       = 1'b0;
      baud_d      = '0;
      bit_idx_d   = 3'd0;
    end

    // disabling discards any pending byte but lets the current frame finish
    if (!enabled) hold_full_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_idx_q   <= 3'd0;
      stop_cnt_q  <= 1'b0;
      shreg_q     <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      out_q       <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      stop_cnt_q  <= stop_cnt_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      out_q       <= out_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_transmitter.sv
// Bench for transmitter: three instances (8N1, 8E1, 8O2) at 4 clocks/bit, checked against
// a frame-timeline model plus a constant vector table and directed corner sequences.
module tb_transmitter;

  localparam int C = 4;
  localparam int PE  [3] = '{0, 1, 1};
  localparam int ODD [3] = '{0, 0, 1};
  localparam int SB  [3] = '{1, 1, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, enabled;
  logic [7:0] data_in;
  logic       valid0, valid1, valid2;
  logic       ready0, ready1, ready2;
  logic       out0, out1, out2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;

  transmitter #(.CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .enabled(enabled), .data_in(data_in), .valid(valid0),
    .ready(ready0), .out(out0), .busy(busy0), .done(done0));
  transmitter #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .enabled(enabled), .data_in(data_in), .valid(valid1),
    .ready(ready1), .out(out1), .busy(busy1), .done(done1));
  transmitter #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .enabled(enabled), .data_in(data_in), .valid(valid2),
    .ready(ready2), .out(out2), .busy(busy2), .done(done2));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic act_ready [3];
  logic act_out   [3];
  logic act_busy  [3];
  logic act_done  [3];

  // model: one frame on the line, at most one byte waiting
  logic       m_cur   [3];
  int         m_start [3];
  logic [7:0] m_byte  [3];
  logic       m_pend  [3];
  logic [7:0] m_pbyte [3];
  logic exp_ready [3];
  logic exp_out   [3];
  logic exp_busy  [3];
  logic exp_done  [3];

  typedef struct {
    logic       r;
    logic       en;
    logic       v;
    logic [7:0] d;
    logic       ready;
    logic       out;
    logic       busy;
    logic       done;
  } vec_t;
  vec_t tbl [10];

  function automatic int flen(input int i);
    return 1 + 8 + PE[i] + SB[i];
  endfunction

  function automatic logic fbit(input int i, input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PE[i] != 0 && idx == 9) return (^b) ^ (ODD[i] != 0);
    return 1'b1;
  endfunction

  task automatic chk(input string name, input int i, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s dut%0d cyc=%0d actual=%0b required=%0b", name, i, cyc, act, req);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  task automatic model_edge(input logic r, input logic en, input logic [2:0] v, input logic [7:0] d);
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        m_cur[i] = 1'b0; m_pend[i] = 1'b0;
        exp_out[i] = 1'b1; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
      end else begin
        logic acc;
        acc = v[i] && exp_ready[i];
        exp_done[i] = 1'b0;
        if (m_cur[i] && cyc == m_start[i] + flen(i) * C) begin
          exp_done[i] = 1'b1;
          m_cur[i] = 1'b0;
        end
        if (m_pend[i]) begin
          if (!en) m_pend[i] = 1'b0;
          else if (!m_cur[i]) begin
            m_cur[i] = 1'b1; m_start[i] = cyc; m_byte[i] = m_pbyte[i]; m_pend[i] = 1'b0;
          end
        end
        if (acc) begin
          m_pend[i] = 1'b1; m_pbyte[i] = d;
        end
        if (m_cur[i]) begin
          exp_out[i]  = fbit(i, m_byte[i], (cyc - m_start[i]) / C);
          exp_busy[i] = 1'b1;
        end else begin
          exp_out[i]  = 1'b1;
          exp_busy[i] = 1'b0;
        end
      end
    end
  endtask

  // drive inputs, sample ready before the edge, update the model at the edge, sample outputs at negedge
  task automatic step(input logic r, input logic en, input logic [2:0] v, input logic [7:0] d);
    rst = r; enabled = en; {valid2, valid1, valid0} = v; data_in = d;
    #1;
    act_ready[0] = ready0; act_ready[1] = ready1; act_ready[2] = ready2;
    for (int i = 0; i < 3; i++) exp_ready[i] = en && !r && !m_pend[i];
    @(posedge clk);
    model_edge(r, en, v, d);
    @(negedge clk);
    act_out[0]  = out0;  act_out[1]  = out1;  act_out[2]  = out2;
    act_busy[0] = busy0; act_busy[1] = busy1; act_busy[2] = busy2;
    act_done[0] = done0; act_done[1] = done1; act_done[2] = done2;
    for (int i = 0; i < 3; i++) begin
      chk("ready", i, act_ready[i], exp_ready[i]);
      chk("out",   i, act_out[i],   exp_out[i]);
      chk("busy",  i, act_busy[i],  exp_busy[i]);
      chk("done",  i, act_done[i],  exp_done[i]);
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 3'b000, 8'h00);
    step(1'b1, 1'b1, 3'b000, 8'h00);
    step(1'b0, 1'b1, 3'b000, 8'h00);
  endtask

  task automatic send(input int i, input logic [7:0] b, output int e0);
    logic got;
    got = 1'b0;
    e0 = -1;
    for (int n = 0; n < 200 && !got; n++) begin
      step(1'b0, 1'b1, 3'(1 << i), b);
      if (exp_ready[i]) begin
        got = 1'b1;
        e0 = cyc;
      end
    end
    if (!got) chk_int("accept_timeout", 0, 1);
  endtask

  // idle until done; optionally check the line value at one edge offset from e0
  task automatic wait_done(input int i, input int e0, input int off, input int bit_off,
                           input logic bit_exp, input logic en);
    logic got;
    got = 1'b0;
    for (int n = 0; n < 150 && !got; n++) begin
      step(1'b0, en, 3'b000, 8'h00);
      if (cyc - e0 == bit_off) chk("line_bit", i, act_out[i], bit_exp);
      if (act_done[i]) begin
        chk_int("done_offset", cyc - e0, off);
        got = 1'b1;
      end
    end
    if (!got) chk_int("done_timeout", 0, 1);
  endtask

  initial begin
    int e0, e1, ndone, nacc;
    for (int i = 0; i < 3; i++) begin
      m_cur[i] = 1'b0; m_pend[i] = 1'b0; m_start[i] = 0;
      m_byte[i] = 8'h00; m_pbyte[i] = 8'h00;
    end

    // reset, release, then 0xA5 accepted at E0 (entry 4); line low E1..E4, bit0 (=1) from E5
    tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 10; k++) begin
      step(tbl[k].r, tbl[k].en, {2'b00, tbl[k].v}, tbl[k].d);
      chk("tbl_ready", 0, act_ready[0], tbl[k].ready);
      chk("tbl_out",   0, act_out[0],   tbl[k].out);
      chk("tbl_busy",  0, act_busy[0],  tbl[k].busy);
      chk("tbl_done",  0, act_done[0],  tbl[k].done);
    end
    e0 = cyc - 5;
    wait_done(0, e0, 41, 10, 1'b0, 1'b1);
    chk("a5_idle_busy", 0, act_busy[0], 1'b0);

    // back-to-back 0x00 / 0xFF with valid held high
    do_reset();
    send(0, 8'h00, e0);
    send(0, 8'hFF, e1);
    chk_int("ff_accept", e1 - e0, 2);
    wait_done(0, e0, 41, -1, 1'b0, 1'b1);
    wait_done(0, e0, 81, 42, 1'b0, 1'b1);

    // parity: even on 0x07 -> 1, odd (two stop bits) -> 0
    do_reset();
    send(1, 8'h07, e0);
    wait_done(1, e0, 45, 38, 1'b1, 1'b1);
    send(2, 8'h07, e0);
    wait_done(2, e0, 49, 38, 1'b0, 1'b1);

    // reset during data bit 3
    do_reset();
    send(0, 8'h3C, e0);
    while (cyc < e0 + 18) step(1'b0, 1'b1, 3'b000, 8'h00);
    step(1'b1, 1'b1, 3'b000, 8'h00);
    chk("rst_out",  0, act_out[0],  1'b1);
    chk("rst_busy", 0, act_busy[0], 1'b0);
    ndone = 0;
    for (int n = 0; n < 60; n++) begin
      step(1'b0, 1'b1, 3'b000, 8'h00);
      if (act_done[0]) ndone++;
    end
    chk_int("rst_no_done", ndone, 0);

    // disable mid-frame with a byte pending
    do_reset();
    send(0, 8'h55, e0);
    send(0, 8'h81, e1);
    while (cyc < e0 + 15) step(1'b0, 1'b1, 3'b000, 8'h00);
    wait_done(0, e0, 41, 17, 1'b0, 1'b0);
    for (int n = 0; n < 20; n++) begin
      step(1'b0, 1'b0, 3'b001, 8'h81);
      chk("dis_out",   0, act_out[0],   1'b1);
      chk("dis_ready", 0, act_ready[0], 1'b0);
      chk("dis_busy",  0, act_busy[0],  1'b0);
    end

    // random traffic on all three instances against the model
    do_reset();
    nacc = 0;
    for (int n = 0; n < 30000 && nacc < 256; n++) begin
      logic       en;
      logic [2:0] v;
      en = ($urandom_range(63) != 0);
      v  = 3'($urandom_range(7));
      step(1'b0, en, v, 8'($urandom));
      if (v[0] && exp_ready[0]) nacc++;
    end
    chk_int("random_accepts", nacc, 256);
    for (int n = 0; n < 120; n++) step(1'b0, 1'b1, 3'b000, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
